// File: rtl/reg_writeback_pkg.sv
// Shared constants and types for the register writeback slice.
// Register file geometry and the writeback entry bundle.
package reg_writeback_pkg;

    localparam int REG_AW   = 5;
    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;

    localparam logic [REG_AW-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_LSU  = 2'd1,
        SRC_FIFO = 2'd2,
        SRC_BYP  = 2'd3
    } wb_src_e;

    function automatic logic [NUM_REGS-1:0] rd_onehot(
        input logic [REG_AW-1:0] rd
    );
        logic [NUM_REGS-1:0] m;
        m     = '0;
        m[rd] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/reg_writeback_wb_fifo.sv
// Small synchronous FIFO buffering ALU results.
// Count is one bit wider than the pointers so full and empty differ.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL_CNT);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer and occupancy tracking; pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/reg_writeback.sv
// Writeback arbiter: LSU > buffered ALU > ALU bypass into one
// registered write port, plus a pending-writer scoreboard.
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int ALU_FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                issue_valid,
    input  logic [REG_AW-1:0]   issue_rd,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [REG_AW-1:0]   alu_rd,
    input  logic [XLEN-1:0]     alu_data,
    input  logic                lsu_valid,
    input  logic [REG_AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0]     lsu_data,
    output logic                write_enable,
    output logic [REG_AW-1:0]   write_addr,
    output logic [XLEN-1:0]     write_data,
    output logic [NUM_REGS-1:0] busy
);

    localparam int CW = $clog2(ALU_FIFO_DEPTH) + 1;

    wb_entry_t           alu_ent;
    wb_entry_t           fifo_head;
    wb_entry_t           sel_ent;
    wb_src_e             sel_src;
    logic                sel_valid;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CW-1:0]       fifo_count;
    logic                fifo_push;
    logic                fifo_pop;
    logic                alu_fire;
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] busy_next;

    assign alu_ent   = '{rd: alu_rd, data: alu_data};
    assign alu_ready = !fifo_full;
    assign alu_fire  = alu_valid && alu_ready;
    assign sel_valid = (sel_src != SRC_NONE);
    assign fifo_pop  = (sel_src == SRC_FIFO);
    assign fifo_push = alu_fire && (sel_src != SRC_BYP) && !flush;
    assign busy      = busy_q;

    wb_fifo #(
        .DEPTH (ALU_FIFO_DEPTH),
        .WIDTH ($bits(wb_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (alu_ent),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Pick the single source feeding the write port this cycle.
    always_comb begin
        sel_src = SRC_NONE;
        sel_ent = '0;
        priority case (1'b1)
            lsu_valid: begin
                sel_src = SRC_LSU;
                sel_ent = '{rd: lsu_rd, data: lsu_data};
            end
            !fifo_empty: begin
                sel_src = SRC_FIFO;
                sel_ent = fifo_head;
            end
            alu_fire: begin
                sel_src = SRC_BYP;
                sel_ent = alu_ent;
            end
            default: ;
        endcase
    end

    // Scoreboard update: a new issue beats a same-cycle retire.
    always_comb begin
        clr_mask  = sel_valid ? rd_onehot(sel_ent.rd) : '0;
        set_mask  = issue_valid ? rd_onehot(issue_rd) : '0;
        busy_next = ((busy_q & ~clr_mask) | set_mask)
                  & ~rd_onehot(ZERO_REG);
    end

    // Registered write port; rd=0 results retire silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_enable <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
        end else if (flush) begin
            write_enable <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
        end else begin
            write_enable <= sel_valid && (sel_ent.rd != ZERO_REG);
            write_addr   <= sel_ent.rd;
            write_data   <= sel_ent.data;
        end
    end

    // Pending-writer bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else if (flush) busy_q <= '0;
        else busy_q <= busy_next;
    end

    // Occupancy and empty flag must agree.
    a_fifo_empty: assert property (
        @(posedge clk) disable iff (!rst_n)
        fifo_empty == (fifo_count == '0)
    );

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 The block SHALL have parameter ALU_FIFO_DEPTH, default 4, the ALU result buffer depth (power of two, at least 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port flush, input, 1 bit: pipeline flush (mispredict), synchronous.
REQ-005 The block SHALL have ports issue_valid (input, 1) and issue_rd (input, 5): an instruction issued this cycle will write register rd.
REQ-006 The block SHALL have ports alu_valid (input, 1), alu_ready (output, 1), alu_rd (input, 5) and alu_data (input, 32): ALU result valid/ready channel.
REQ-007 The block SHALL have ports lsu_valid (input, 1), lsu_rd (input, 5) and lsu_data (input, 32): load result channel, always accepted, no ready.
REQ-008 The block SHALL have ports write_enable (output, 1), write_addr (output, 5) and write_data (output, 32): register-file write port, registered, active-high.
REQ-009 The block SHALL have port busy, output, 32 bits: scoreboard, where bit r=1 means register r has a pending writer.

Function
REQ-010 The ALU channel SHALL transfer when alu_valid && alu_ready; alu_ready SHALL be !fifo_full, combinationally.
REQ-011 The write-port register SHALL load on every edge from exactly one source, in priority order: (1) LSU if lsu_valid; (2) FIFO head if the FIFO is non-empty, popping it; (3) ALU input directly if alu_valid && FIFO empty (bypass, not enqueued); otherwise write_enable SHALL be 0 next cycle.
REQ-012 An accepted ALU result not taken by REQ-011 SHALL be enqueued; a pop and a push in the same cycle SHALL be legal even when the FIFO is full-minus-zero, keeping the count unchanged.
REQ-013 Latency SHALL be 1 cycle: a result selected at edge N SHALL appear on write_enable/addr/data during cycle N+1, held for exactly one cycle.
REQ-014 Results with rd=0 SHALL be consumed (popped/accepted) but SHALL produce write_enable=0.
REQ-015 FIFO pointers SHALL wrap modulo ALU_FIFO_DEPTH; full/empty SHALL be distinguished by a count of log2(DEPTH)+1 bits.
REQ-016 busy[r] SHALL be set at the edge where issue_valid && issue_rd==r (r!=0).
REQ-017 busy[r] SHALL be cleared at the edge where the write-port register loads a result with rd==r.
REQ-018 Simultaneous set and clear of the same r SHALL leave busy[r]=1 (the newer producer wins).
REQ-019 busy[0] SHALL be constant 0.
REQ-020 When flush=1 at an edge, the block SHALL clear all busy bits, empty the FIFO, drop any lsu/alu input that cycle, and drive write_enable=0 next cycle; flush SHALL dominate issue_valid.
REQ-021 alu_ready SHALL remain !fifo_full during the flush cycle; a handshake in that cycle SHALL be considered accepted and discarded.

Reset
REQ-022 While rst_n=0 (asynchronous): write_enable=0, write_addr=0, write_data=0, busy=0, FIFO empty, alu_ready=1.
REQ-023 Reset asserted mid-operation SHALL discard all buffered results with no write emitted; the first write SHALL be possible at the second edge after rst_n rises.

Structure
REQ-024 Register address width (5), data width (32), register count (32) and the zero-register index SHALL come from the shared config constants package.
REQ-025 The ALU buffer SHALL be a separate sub-module, wb_fifo (parameterised depth/width, push/pop/full/empty/count); the arbiter and scoreboard SHALL remain in reg_writeback.

Verification
REQ-026 Scenario: alu_valid, rd=5, data=0x1234, FIFO empty, no LSU -> next cycle write_enable=1, addr=5, data=0x1234.
REQ-027 Scenario: lsu (rd=3, 0xAAAA) and alu (rd=4, 0xBBBB) in the same cycle -> cycle+1 writes r3, cycle+2 writes r4.
REQ-028 Scenario: LSU valid for 6 cycles while ALU streams -> alu_ready drops after 4 enqueues, then 4 ALU writes drain in FIFO order.
REQ-029 Scenario: issue rd=7, then a write with rd=7 in the same cycle as a new issue rd=7 -> busy[7] remains 1; a later write clears it.
REQ-030 Scenario: FIFO holds 3 entries, flush=1 -> busy=0 and write_enable=0 next cycle, count=0; an rd=0 result -> no write_enable.
REQ-031 Scenario: rst_n pulsed low mid-cycle with a full FIFO -> outputs go 0 immediately, and no stale write follows.
